// File: rtl/punc_fetch_unit_pkg.sv
// Shared PUnC fetch definitions: word width, reset PC, LC3 PC increment and
// the types used between the fetch unit and its queues.
package punc_fetch_unit_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 16'h0000;
    localparam word_t PC_INC           = 16'h0001;

    typedef struct packed {
        word_t word;
        word_t pc;
    } iq_entry_t;

    typedef enum logic {
        ST_FETCHING = 1'b0,
        ST_HALTED   = 1'b1
    } fetch_state_e;

    function automatic word_t pc_inc(input word_t pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/punc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read channel, instruction handoff to
// the control unit, and the control unit's redirect/halt requests.
interface punc_fetch_unit_if;

    logic                       mem_req;
    punc_fetch_unit_pkg::word_t mem_addr;
    logic                       mem_gnt;
    logic                       mem_rvalid;
    punc_fetch_unit_pkg::word_t mem_rdata;

    logic                       ir_valid;
    punc_fetch_unit_pkg::word_t ir;
    punc_fetch_unit_pkg::word_t ir_pc;
    logic                       ir_ready;

    logic                       redirect;
    punc_fetch_unit_pkg::word_t redirect_pc;
    logic                       halt;
    logic                       fetch_idle;

    modport master (
        output mem_req, mem_addr, ir_valid, ir, ir_pc, fetch_idle,
        input  mem_gnt, mem_rvalid, mem_rdata, ir_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr, ir_valid, ir, ir_pc, fetch_idle,
        output mem_gnt, mem_rvalid, mem_rdata, ir_ready, redirect, redirect_pc, halt
    );

endinterface

// File: rtl/punc_fetch_fifo.sv
// Parameterised synchronous FIFO with flush; used for the instruction queue
// and for the PC tags of in-flight reads.
module punc_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: defaults first so every path assigns each _d and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push_i |-> !full_o);

endmodule

// File: rtl/punc_fetch_unit.sv
// PUnC instruction fetch: credit-limited in-order reads, instruction queue,
// redirect with discard of stale responses, and sticky halt.
module punc_fetch_unit
    import punc_fetch_unit_pkg::*;
#(
    parameter int    DEPTH    = 2,
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    punc_fetch_unit_if.master  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    word_t            pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             accept, rsp, rsp_live, iq_pop;
    logic [CNT_W:0]   credit_used;
    iq_entry_t        iq_in, iq_head;
    logic [CNT_W-1:0] iq_count, tag_count;
    logic             iq_full, iq_empty, tag_full, tag_empty;
    word_t            tag_pc;

    // Credits cover both queued words and reads still owed by memory, stale ones included.
    assign credit_used  = {1'b0, outstanding_q} + {1'b0, iq_count};
    assign bus.mem_req  = (state_q == ST_FETCHING) && !rst && (credit_used < (CNT_W+1)'(DEPTH));
    assign bus.mem_addr = pc_q;

    assign accept   = bus.mem_req && bus.mem_gnt;
    assign rsp      = bus.mem_rvalid;
    assign rsp_live = rsp && (drop_q == '0) && !bus.redirect;
    assign iq_pop   = bus.ir_valid && bus.ir_ready;
    assign iq_in    = '{word: bus.mem_rdata, pc: pc_inc(tag_pc)};

    assign bus.ir_valid   = !iq_empty;
    assign bus.ir         = bus.ir_valid ? iq_head.word : '0;
    assign bus.ir_pc      = bus.ir_valid ? iq_head.pc   : '0;
    assign bus.fetch_idle = (state_q == ST_HALTED) && (outstanding_q == '0);

    punc_fetch_fifo #(.WIDTH($bits(iq_entry_t)), .DEPTH(DEPTH)) u_iq (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.redirect),
        .push_i  (rsp_live),
        .data_i  (iq_in),
        .pop_i   (iq_pop),
        .data_o  (iq_head),
        .count_o (iq_count),
        .full_o  (iq_full),
        .empty_o (iq_empty)
    );

    punc_fetch_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tag (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (accept),
        .data_i  (pc_q),
        .pop_i   (rsp),
        .data_o  (tag_pc),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);
        drop_d        = drop_q;

        case (state_q)
            ST_FETCHING: if (bus.halt) state_d = ST_HALTED;
            ST_HALTED:   state_d = ST_HALTED;
            default:     state_d = ST_FETCHING;
        endcase

        // Redirect makes every read still owed by memory stale, including one granted now.
        if (bus.redirect) begin
            pc_d   = bus.redirect_pc;
            drop_d = outstanding_d;
        end else begin
            if (accept) pc_d = pc_inc(pc_q);
            if (rsp && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCHING;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    a_rvalid_owed:  assert property (@(posedge clk) disable iff (rst) rsp |-> (outstanding_q != '0) && !tag_empty);
    a_drop_bounded: assert property (@(posedge clk) disable iff (rst) (drop_q <= outstanding_q));
    a_tag_tracks:   assert property (@(posedge clk) disable iff (rst) (tag_count == outstanding_q));
    a_tag_room:     assert property (@(posedge clk) disable iff (rst) accept |-> !tag_full);
    a_iq_room:      assert property (@(posedge clk) disable iff (rst) rsp_live |-> !iq_full);

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Scoreboard bench for punc_fetch_unit: memory model with random grant and
// latency, fetch-order reference model, and a monitor on the ir handshake.
module tb_punc_fetch_unit;
    import punc_fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    punc_fetch_unit_if bus ();

    punc_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic word_t mem_word(input word_t a);
        return a ^ 16'hA5A5;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        word_t addr;
        int    ready;
    } pend_t;

    pend_t pend[$];
    int    cyc     = 0;
    int    gnt_pct = 100;
    int    lat_min = 1;
    int    lat_max = 1;

    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (bus.mem_rvalid) void'(pend.pop_front());
                if (bus.mem_req && bus.mem_gnt)
                    pend.push_back('{bus.mem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            end
            @(posedge clk);
            cyc++;
            #2;
            bus.mem_rvalid = !rst && (pend.size() > 0) && (pend[0].ready <= cyc);
            bus.mem_rdata  = bus.mem_rvalid ? mem_word(pend[0].addr) : '0;
            bus.mem_gnt    = int'($urandom_range(99, 0)) < gnt_pct;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        word_t ir;
        word_t ir_pc;
    } exp_t;

    exp_t  exp_q[$];
    word_t m_pc     = 16'h0000;
    logic  m_halted = 1'b0;

    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            m_pc     = 16'h0000;
            m_halted = 1'b0;
            exp_q.delete();
        end else begin
            if (m_halted)
                check("no_req_when_halted", 32'(bus.mem_req), 32'd0);
            else if (bus.mem_req)
                check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
            if (bus.mem_req && bus.mem_gnt) begin
                exp_q.push_back('{mem_word(m_pc), m_pc + 16'd1});
                m_pc = m_pc + 16'd1;
            end
            if (bus.redirect) begin
                exp_q.delete();
                m_pc = bus.redirect_pc;
            end
            if (bus.halt) m_halted = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (!rst && bus.ir_valid && bus.ir_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir: got ir=%h ir_pc=%h expected no word (t=%0t)", bus.ir, bus.ir_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ir", 32'(bus.ir), 32'(e.ir));
                check("ir_pc", 32'(bus.ir_pc), 32'(e.ir_pc));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit chk);
        next_cycle();
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.halt     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
            check("rst_ir", 32'(bus.ir), 32'd0);
            check("rst_ir_pc", 32'(bus.ir_pc), 32'd0);
            check("rst_mem_req", 32'(bus.mem_req), 32'd0);
            check("rst_fetch_idle", 32'(bus.fetch_idle), 32'd0);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ir_valid && n < budget);
        check(name, 32'(bus.ir_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fetch_idle && n < budget);
        check(name, 32'(bus.fetch_idle), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  grants;
        int  d0;
        bit  found;

        bus.ir_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;

        // Streaming fetch with single-cycle memory; first word three cycles after reset.
        apply_reset(1'b1);
        @(negedge clk) check("p1_valid_c1", 32'(bus.ir_valid), 32'd0);
        @(negedge clk) check("p1_valid_c2", 32'(bus.ir_valid), 32'd0);
        @(negedge clk) check("p1_valid_c3", 32'(bus.ir_valid), 32'd1);
        check("p1_first_ir", 32'(bus.ir), 32'h0000_A5A5);
        check("p1_first_ir_pc", 32'(bus.ir_pc), 32'h0000_0001);
        repeat (20) next_cycle();

        // Back-pressure: credit limit stops requests at DEPTH.
        bus.ir_ready = 1'b0;
        apply_reset(1'b0);
        grants = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_gnt) grants++;
        end
        check("p2_grants", 32'(grants), 32'd2);
        check("p2_req_blocked", 32'(bus.mem_req), 32'd0);
        next_cycle();
        bus.ir_ready = 1'b1;
        next_cycle();
        bus.ir_ready = 1'b0;
        @(negedge clk);
        check("p2_req_resumes", 32'(bus.mem_req), 32'd1);
        check("p2_resume_addr", 32'(bus.mem_addr), 32'h0000_0002);
        next_cycle();
        bus.ir_ready = 1'b1;
        repeat (6) next_cycle();

        // Redirect with two slow reads in flight.
        lat_min = 4;
        lat_max = 4;
        apply_reset(1'b0);
        next_cycle();
        next_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h3000;
        next_cycle();
        bus.redirect = 1'b0;
        wait_valid("p3_valid_timeout", 30);
        check("p3_ir", 32'(bus.ir), 32'(mem_word(16'h3000)));
        check("p3_ir_pc", 32'(bus.ir_pc), 32'h0000_3001);
        repeat (8) next_cycle();

        // Redirect coinciding with a grant and a response.
        lat_min = 1;
        lat_max = 1;
        apply_reset(1'b0);
        next_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h4000;
        @(negedge clk);
        check("p4_gnt_rvalid_redirect", 32'({bus.mem_req, bus.mem_gnt, bus.mem_rvalid}), 32'b111);
        next_cycle();
        bus.redirect = 1'b0;
        wait_valid("p4_valid_timeout", 20);
        check("p4_ir", 32'(bus.ir), 32'(mem_word(16'h4000)));
        check("p4_ir_pc", 32'(bus.ir_pc), 32'h0000_4001);

        // PC wrap at FFFF.
        lat_max = 3;
        next_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        next_cycle();
        bus.redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.ir_valid && bus.ir == mem_word(16'hFFFF)) begin
                found = 1'b1;
                check("p5_wrap_ir_pc", 32'(bus.ir_pc), 32'h0000_0000);
            end
        end
        check("p5_ffff_seen", 32'(found), 32'd1);
        repeat (10) next_cycle();

        // Halt with one read in flight, then reset restarts fetching.
        lat_min = 3;
        lat_max = 3;
        apply_reset(1'b0);
        d0 = delivered;
        bus.halt = 1'b1;
        next_cycle();
        bus.halt = 1'b0;
        @(negedge clk);
        check("p6_not_idle_inflight", 32'(bus.fetch_idle), 32'd0);
        wait_idle("p6_idle_timeout", 20);
        repeat (3) @(negedge clk);
        check("p6_delivered", 32'(delivered - d0), 32'd1);
        check("p6_still_idle", 32'(bus.fetch_idle), 32'd1);
        apply_reset(1'b1);
        @(negedge clk);
        check("p6_restart_req", 32'(bus.mem_req), 32'd1);
        check("p6_restart_addr", 32'(bus.mem_addr), 32'h0000_0000);

        // Randomised traffic with redirects, then halt and drain.
        gnt_pct = 70;
        lat_min = 1;
        lat_max = 4;
        apply_reset(1'b0);
        repeat (400) begin
            next_cycle();
            bus.ir_ready    = $urandom_range(3, 0) != 0;
            bus.redirect    = $urandom_range(19, 0) == 0;
            bus.redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
        end
        next_cycle();
        bus.redirect = 1'b0;
        bus.ir_ready = 1'b1;
        bus.halt     = 1'b1;
        next_cycle();
        bus.halt = 1'b0;
        wait_idle("p7_idle_timeout", 60);
        repeat (5) @(negedge clk);
        check("p7_model_drained", 32'(exp_q.size()), 32'd0);
        check("p7_queue_empty", 32'(bus.ir_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
